// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   state_e     : fetch FSM states
//   RESET_PC    : PC value after reset
//   NOP_INSTR   : word presented toward decode when the buffer is empty
//   HALT_OPCODE : opcode field (bits [15:11]) of the HALT instruction
//   FIFO_DEPTH  : number of fetched instructions buffered toward decode
package ifetch_pkg;

  typedef enum logic [2:0] {
    StIdle,    // no request outstanding
    StWait,    // request outstanding, response kept
    StDrop,    // request outstanding, response discarded
    StPause,   // predecoded HALT, waiting for redirect or halt
    StHalted   // permanently stopped until reset
  } state_e;

  localparam logic [15:0]  RESET_PC    = 16'h0000;
  localparam logic [15:0]  NOP_INSTR   = 16'h0800;
  localparam logic [4:0]   HALT_OPCODE = 5'b00000;
  localparam int unsigned  FIFO_DEPTH  = 2;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry instruction buffer between fetch and decode.
// Entry 0 is always the head; entry 1 shifts down on a pop.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   flush_i        : empty the buffer (beats push)
//   push_i, push_data_i : write one 32-bit {instr, pc_plus2} entry
//   pop_i          : remove the head
//   count_o        : number of valid entries (0..2)
//   head_o         : head entry (stale when count_o == 0)
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  output logic [1:0]  count_o,
  output logic [31:0] head_o
);

  logic [31:0] mem0_q, mem0_d;
  logic [31:0] mem1_q, mem1_d;
  logic [1:0]  count_q, count_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (push_i && pop_i && count_q != 2'd0) begin
      if (count_q == 2'd1) begin
        mem0_d = push_data_i;
      end else begin
        mem0_d = mem1_q;
        mem1_d = push_data_i;
      end
    end else if (push_i && count_q < 2'(FIFO_DEPTH)) begin
      if (count_q == 2'd0) begin
        mem0_d = push_data_i;
      end else begin
        mem1_d = push_data_i;
      end
      count_d = count_q + 2'd1;
    end else if (pop_i && count_q != 2'd0) begin
      mem0_d  = mem1_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem0_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads over a req/ack
// instruction-memory port and buffers up to two {instr, pc+2} entries
// toward decode. Redirects and halts from execute flush the buffer and
// discard any in-flight read.
// Optional build macro: IFETCH_PREDECODE_HALT_EN -- stop requesting after
// an accepted HALT word until execute redirects or halts.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   redirect_valid, redirect_pc : taken control flow from execute
//   halt_in                     : HALT retired in execute
//   imem_req, imem_addr         : read request / address (held until ack)
//   imem_ack, imem_rdata        : read completion / instruction word
//   if_valid, if_ready          : decode handshake
//   if_instr, if_pc_plus2       : head instruction and its PC+2
//   halted                      : fetch permanently stopped
module ifetch_unit
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_in,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] last_pc2_q;

  logic        fifo_push, fifo_pop, fifo_flush;
  logic [1:0]  fifo_count;
  logic [31:0] fifo_head;
  logic [15:0] pc_plus2;
  logic [2:0]  cnt_after;
  logic        slot_after;
  logic        halt_req, redirect;

  assign pc_plus2   = pc_q + 16'd2;
  assign halt_req   = halt_in | halt_pend_q;
  assign redirect   = redirect_valid & ~halt_req;
  assign fifo_pop   = if_valid & if_ready;
  // Occupancy after an accepted push, crediting a same-cycle pop.
  assign cnt_after  = {1'b0, fifo_count} + 3'd1 - {2'b00, fifo_pop};
  assign slot_after = cnt_after < 3'(FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    halt_pend_d = halt_pend_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    if (state_q != StHalted) begin
      halt_pend_d = halt_req;
    end
    unique case (state_q)
      StIdle: begin
        if (halt_req) begin
          fifo_flush = 1'b1;
          state_d    = StHalted;
        end else if (redirect) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc;
          addr_d     = redirect_pc;
          state_d    = StWait;
        end else if (fifo_count < 2'(FIFO_DEPTH)) begin
          addr_d  = pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (halt_req) begin
          fifo_flush = 1'b1;
          state_d    = imem_ack ? StHalted : StDrop;
        end else if (redirect) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc;
          if (imem_ack) begin
            // Same-cycle ack is discarded; the bus is free for the target.
            addr_d  = redirect_pc;
            state_d = StWait;
          end else begin
            state_d = StDrop;
          end
        end else if (imem_ack) begin
          fifo_push = 1'b1;
          pc_d      = pc_plus2;
          state_d   = StIdle;
          if (slot_after) begin
            addr_d  = pc_plus2;
            state_d = StWait;
          end
`ifdef IFETCH_PREDECODE_HALT_EN
          if (imem_rdata[15:11] == HALT_OPCODE) begin
            addr_d  = addr_q;
            state_d = StPause;
          end
`endif
        end
      end
      StDrop: begin
        if (halt_req || redirect) begin
          fifo_flush = 1'b1;
        end
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = halt_req ? StHalted : StIdle;
        end
      end
      StPause: begin
        if (halt_req) begin
          fifo_flush = 1'b1;
          state_d    = StHalted;
        end else if (redirect) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc;
          state_d    = StIdle;
        end
      end
      StHalted: begin
        fifo_flush = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      halt_pend_q <= 1'b0;
      last_pc2_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      halt_pend_q <= halt_pend_d;
      if (if_valid) begin
        last_pc2_q <= fifo_head[15:0];
      end
    end
  end

  ifetch_fifo u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i ({imem_rdata, pc_plus2}),
    .pop_i       (fifo_pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign imem_req    = (state_q == StWait) || (state_q == StDrop);
  assign imem_addr   = addr_q;
  assign halted      = (state_q == StHalted);
  assign if_valid    = (fifo_count != 2'd0);
  assign if_instr    = if_valid ? fifo_head[31:16] : NOP_INSTR;
  assign if_pc_plus2 = if_valid ? fifo_head[15:0] : last_pc2_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt_in = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

`ifdef IFETCH_PREDECODE_HALT_EN
  localparam logic [15:0] HALT_HOLD = 16'h0302;
`else
  localparam logic [15:0] HALT_HOLD = 16'h0002;
`endif

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: never the HALT opcode, distinct per address.
  function automatic logic [15:0] word(input logic [15:0] a);
    return {5'b10101, a[10:0]};
  endfunction

  // Scoreboard consumer: every decode acceptance must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected instr=%h pc2=%h expected none", if_instr, if_pc_plus2);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if ({if_instr, if_pc_plus2} !== e) begin
          n_err++;
          $display("FAIL pop_data instr=%h pc2=%h expected instr=%h pc2=%h",
                   if_instr, if_pc_plus2, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit got);
    int t = 0;
    while (imem_req !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    got = (imem_req === 1'b1);
  endtask

  // Answer one request one cycle after it is seen; the expected entry is
  // derived from the address the test intends, not from the DUT.
  task automatic serve(input logic [15:0] exp_addr, input logic [15:0] data, output bit got,
                       output logic [15:0] addr, output logic v_after,
                       output logic [15:0] i_after);
    wait_req(got);
    addr    = imem_addr;
    v_after = 1'b0;
    i_after = '0;
    if (!got) return;
    step();
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb.push_back({data, exp_addr + 16'd2});
    step();
    imem_ack = 1'b0;
    v_after  = if_valid;
    i_after  = if_instr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_ready = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({imem_req, imem_addr} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_imem req=%b addr=%h expected 0/0000", imem_req, imem_addr);
    end
    n_cmp++;
    if ({if_valid, if_instr, if_pc_plus2, halted} !== {1'b0, 16'h0800, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_if valid=%b instr=%h pc2=%h halted=%b expected 0/0800/0000/0",
               if_valid, if_instr, if_pc_plus2, halted);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL first_req req=%b addr=%h expected 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit got;
    logic [15:0] a, ins;
    logic v;
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] ea;
      ea = 16'(2 * k);
      serve(ea, word(ea), got, a, v, ins);
      n_cmp++;
      if (got !== 1'b1 || a !== ea) begin
        n_err++;
        $display("FAIL seq_addr got=%b addr=%h expected %h", got, a, ea);
      end
      n_cmp++;
      if (v !== 1'b1 || ins !== word(ea)) begin
        n_err++;
        $display("FAIL seq_latency valid=%b instr=%h expected 1/%h", v, ins, word(ea));
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    logic [15:0] a, ins;
    logic v;
    int reqs = 0;
    step();
    step();
    if_ready = 1'b0;
    serve(16'h0006, word(16'h0006), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'h0006) begin
      n_err++;
      $display("FAIL bp_addr0 got=%b addr=%h expected 0006", got, a);
    end
    serve(16'h0008, word(16'h0008), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'h0008 || v !== 1'b1 || ins !== word(16'h0006)) begin
      n_err++;
      $display("FAIL bp_addr1 got=%b addr=%h head=%h expected 0008 head %h",
               got, a, ins, word(16'h0006));
    end
    repeat (10) begin
      step();
      if (imem_req !== 1'b0) reqs++;
    end
    n_cmp++;
    if (reqs != 0) begin
      n_err++;
      $display("FAIL bp_no_req req_cycles=%0d expected 0", reqs);
    end
    n_cmp++;
    if (if_valid !== 1'b1 || if_instr !== word(16'h0006) || if_pc_plus2 !== 16'h0008) begin
      n_err++;
      $display("FAIL bp_head valid=%b instr=%h pc2=%h expected 1/%h/0008",
               if_valid, if_instr, if_pc_plus2, word(16'h0006));
    end
    if_ready = 1'b1;
  endtask

  task automatic test_redirect_ack();
    bit got;
    wait_req(got);
    n_cmp++;
    if (got !== 1'b1 || imem_addr !== 16'h000A) begin
      n_err++;
      $display("FAIL rda_addr got=%b addr=%h expected 000a", got, imem_addr);
    end
    step();
    imem_ack       = 1'b1;
    imem_rdata     = word(16'h000A);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    step();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rda_discard valid=%b expected 0", if_valid);
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
      n_err++;
      $display("FAIL rda_target req=%b addr=%h expected 1/0100", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_drop();
    bit got;
    logic [15:0] a, ins;
    logic v;
    if_ready = 1'b0;
    serve(16'h0100, word(16'h0100), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'h0100) begin
      n_err++;
      $display("FAIL drop_first got=%b addr=%h expected 0100", got, a);
    end
    wait_req(got);
    n_cmp++;
    if (got !== 1'b1 || imem_addr !== 16'h0102 || if_valid !== 1'b1
        || if_instr !== word(16'h0100)) begin
      n_err++;
      $display("FAIL drop_pre addr=%h valid=%b instr=%h expected 0102/1/%h",
               imem_addr, if_valid, if_instr, word(16'h0100));
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    step();
    redirect_valid = 1'b0;
    sb.delete();
    n_cmp++;
    if ({if_valid, if_instr, if_pc_plus2} !== {1'b0, 16'h0800, 16'h0102}) begin
      n_err++;
      $display("FAIL drop_flush valid=%b instr=%h pc2=%h expected 0/0800/0102",
               if_valid, if_instr, if_pc_plus2);
    end
    if_ready = 1'b1;
    step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0102) begin
      n_err++;
      $display("FAIL drop_hold req=%b addr=%h expected 1/0102", imem_req, imem_addr);
    end
    step();
    imem_ack   = 1'b1;
    imem_rdata = word(16'h0102);
    step();
    imem_ack = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_discard valid=%b expected 0", if_valid);
    end
    serve(16'h0200, word(16'h0200), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'h0200) begin
      n_err++;
      $display("FAIL drop_target got=%b addr=%h expected 0200", got, a);
    end
  endtask

  task automatic test_wrap();
    bit got;
    logic [15:0] a, ins;
    logic v;
    wait_req(got);
    step();
    imem_ack       = 1'b1;
    imem_rdata     = word(16'h0202);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    step();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    serve(16'hFFFE, word(16'hFFFE), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'hFFFE) begin
      n_err++;
      $display("FAIL wrap_top got=%b addr=%h expected fffe", got, a);
    end
    serve(16'h0000, word(16'h0000), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap_zero got=%b addr=%h expected 0000", got, a);
    end
  endtask

`ifdef IFETCH_PREDECODE_HALT_EN
  task automatic test_predecode();
    bit got;
    logic [15:0] a, ins;
    logic v;
    int reqs = 0;
    wait_req(got);
    n_cmp++;
    if (got !== 1'b1 || imem_addr !== 16'h0002) begin
      n_err++;
      $display("FAIL pd_addr got=%b addr=%h expected 0002", got, imem_addr);
    end
    step();
    imem_ack   = 1'b1;
    imem_rdata = 16'h0000;
    sb.push_back({16'h0000, 16'h0004});
    step();
    imem_ack = 1'b0;
    repeat (6) begin
      step();
      if (imem_req !== 1'b0) reqs++;
    end
    n_cmp++;
    if (reqs != 0) begin
      n_err++;
      $display("FAIL pd_pause req_cycles=%0d expected 0", reqs);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0300;
    step();
    redirect_valid = 1'b0;
    serve(16'h0300, word(16'h0300), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'h0300) begin
      n_err++;
      $display("FAIL pd_resume got=%b addr=%h expected 0300", got, a);
    end
  endtask
`endif

  task automatic test_halt();
    bit got;
    int bad = 0;
    wait_req(got);
    n_cmp++;
    if (got !== 1'b1 || imem_addr !== HALT_HOLD) begin
      n_err++;
      $display("FAIL halt_pre got=%b addr=%h expected %h", got, imem_addr, HALT_HOLD);
    end
    halt_in        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0400;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({if_valid, halted, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, HALT_HOLD}) begin
      n_err++;
      $display("FAIL halt_drop valid=%b halted=%b req=%b addr=%h expected 0/0/1/%h",
               if_valid, halted, imem_req, imem_addr, HALT_HOLD);
    end
    step();
    imem_ack   = 1'b1;
    imem_rdata = word(HALT_HOLD);
    step();
    imem_ack = 1'b0;
    n_cmp++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_enter halted=%b req=%b valid=%b expected 1/0/0",
               halted, imem_req, if_valid);
    end
    repeat (20) begin
      step();
      if (imem_req !== 1'b0 || halted !== 1'b1 || if_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL halt_sticky bad_cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_restart();
    bit got;
    logic [15:0] a, ins;
    logic v;
    rst_n   = 1'b0;
    halt_in = 1'b0;
    step();
    n_cmp++;
    if ({halted, imem_req, if_valid, if_instr, if_pc_plus2}
        !== {1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000}) begin
      n_err++;
      $display("FAIL rst_state halted=%b req=%b valid=%b instr=%h pc2=%h expected 0/0/0/0800/0000",
               halted, imem_req, if_valid, if_instr, if_pc_plus2);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_first req=%b addr=%h expected 1/0000", imem_req, imem_addr);
    end
    serve(16'h0000, word(16'h0000), got, a, v, ins);
    wait_req(got);
    n_cmp++;
    if (got !== 1'b1 || imem_addr !== 16'h0002) begin
      n_err++;
      $display("FAIL rst_second got=%b addr=%h expected 0002", got, imem_addr);
    end
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'h1234;
    step();
    imem_ack = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_stale valid=%b req=%b addr=%h expected 0/1/0000",
               if_valid, imem_req, imem_addr);
    end
    serve(16'h0000, word(16'h0000), got, a, v, ins);
    n_cmp++;
    if (got !== 1'b1 || a !== 16'h0000 || v !== 1'b1 || ins !== word(16'h0000)) begin
      n_err++;
      $display("FAIL rst_refetch got=%b addr=%h valid=%b instr=%h expected 0000/1/%h",
               got, a, v, ins, word(16'h0000));
    end
    repeat (4) step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain pending=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_ack();
    test_redirect_drop();
    test_wrap();
`ifdef IFETCH_PREDECODE_HALT_EN
    test_predecode();
`endif
    test_halt();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
